counter_updn: RTL and testbench
===============================

# counter_updn

Parametrised modulo-N up/down counter, the general-purpose successor to the lab's fixed 2-bit counter. It adds:
- configurable width and modulus;
- direction control and synchronous load/clear;
- wrap or saturate mode;
- a sticky overflow flag;
- a cascade-ready terminal-count output.

It sits in the lab datapaths wherever a counter feeds display decoders, dividers or chained decade stages.

## Interface
Parameters:
- WIDTH, 4, counter width in bits, 1..16
- MODULUS, 10, count range 0..MODULUS-1, legal 2..2^WIDTH
- SATURATE, 0, 0 = wrap at the ends, 1 = hold at the ends

Ports:
- clk  in  1  rising-edge clock
- r  in  1  reset, asynchronous, active-high
- clr  in  1  synchronous clear to 0
- ld  in  1  synchronous load of d
- d  in  WIDTH  load value
- en  in  1  count enable; en=0 holds q
- up  in  1  direction: 1 increments, 0 decrements
- q  out  WIDTH  registered count value
- tc  out  1  terminal count, combinational, used as the next stage's en
- ovf  out  1  sticky overflow/underflow flag, registered

## Operation
- Priority on each clk edge: r > clr > ld > en > hold.
- r asserted:
  - q=0 and ovf=0 immediately, independent of clk.
  - Both are held while r=1.
  - tc=0 while r=1.
- clr=1: q<=0 and ovf<=0.
- ld=1 (clr=0):
  - q<=d if d<MODULUS, else q<=MODULUS-1.
  - ovf is unchanged.
- en=1, up=1:
  - q<MODULUS-1: q<=q+1.
  - q==MODULUS-1 and SATURATE=0: q<=0 and ovf<=1.
  - q==MODULUS-1 and SATURATE=1: q holds and ovf<=1.
- en=1, up=0:
  - q>0: q<=q-1.
  - q==0 and SATURATE=0: q<=MODULUS-1 and ovf<=1.
  - q==0 and SATURATE=1: q holds and ovf<=1.
- en=0: q and ovf hold.
- ovf is cleared only by r or clr.
- tc = en & ~ld & ~clr & ~r & (up ? q==MODULUS-1 : q==0).
  - tc is high exactly on cycles where this stage wraps or saturates on the next edge.
  - tc is masked during ld and clr so that a chained stage never counts on a non-counting cycle.
- Arithmetic:
  - Computed in WIDTH bits.
  - q never leaves 0..MODULUS-1 by any input sequence.
  - MODULUS=2^WIDTH is legal; the wrap then coincides with natural rollover.
- A direction change takes effect on the next edge; no state is kept between edges apart from q and ovf.

## Timing
- Reset values: q=0, ovf=0, tc=0.
- Latency:
  - ld, clr and count: q updates on the first rising edge with the control sampled high. One cycle, no pipelining.
  - ovf: set on the same edge as the wrap or saturate event.
- tc is purely combinational from q, en, up, ld, clr and r, and stays valid in the same cycle as the inputs.
- Cascade: stage k+1 has en = tc of stage k. Both stages advance on the same edge.
- Reset mid-count: r asserted asynchronously between edges forces q=0 at once. The first count after release happens at the first edge with r=0 and en=1.
- Simultaneous events:
  - ld+en: ld wins and no count occurs.
  - clr+ld: clr wins.
  - Saturated end with en=1 held: q holds and ovf stays 1.

## Test plan
- Reset and idle: r=1 mid-count at q=7, between edges -> q=0, ovf=0 immediately; r release with en=0 -> q holds 0 for 5 cycles, tc=0.
- Decade wrap up (WIDTH=4, MODULUS=10, SATURATE=0): en=1, up=1 for 12 cycles from 0 -> q 1..9,0,1,2; tc=1 only while q=9; ovf=1 from the 0 after 9 onward.
- Down wrap and saturate: up=0, en=1 from q=0 -> q=9 with SATURATE=0; same stimulus with SATURATE=1 -> q stays 0, ovf=1, tc=1 continuously.
- Load clamp and priority: ld=1, d=13 -> q=9; ld=1, d=4, en=1 -> q=4 with no increment and tc=0; clr=1, ld=1 -> q=0, ovf=0.
- Cascade of two decade stages counting up for 100 cycles from 00 -> units/tens show 00..99 then 00; tens ovf set exactly at the 99->00 edge; no double counts.
- Full binary range (WIDTH=3, MODULUS=8): 9 up-counts from 0 -> 1..7,0,1; ovf set on the 7->0 edge.

Source files
------------

// File: rtl/counter_updn_if.sv
// Control/status bundle for counter_updn: load/clear/count controls in, count and flags out.
interface counter_updn_if #(
   parameter int WIDTH = 4
);
   logic             clr;
   logic             ld;
   logic [WIDTH-1:0] d;
   logic             en;
   logic             up;
   logic [WIDTH-1:0] q;
   logic             tc;
   logic             ovf;

   modport master (
      output clr, ld, d, en, up,
      input  q, tc, ovf
   );

   modport slave (
      input  clr, ld, d, en, up,
      output q, tc, ovf
   );
endinterface

// File: rtl/counter_updn.sv
// Modulo-MODULUS up/down counter with wrap/saturate ends, sticky overflow and cascade terminal count.
module counter_updn #(
   parameter int WIDTH    = 4,
   parameter int MODULUS  = 10,
   parameter int SATURATE = 0
) (
   input  logic           clk,
   input  logic           r,
   counter_updn_if.slave  bus
);

   localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

   logic [WIDTH-1:0] q_reg;
   logic             ovf_reg;
   logic             at_end;
   logic [WIDTH-1:0] ld_val;

   assign at_end = bus.up ? (q_reg == TOP) : (q_reg == '0);

   // Extra top bit lets MODULUS = 2^WIDTH accept every d without clamping.
   assign ld_val = ({1'b0, bus.d} < MOD_EXT) ? bus.d : TOP;

   assign bus.tc  = bus.en & ~bus.ld & ~bus.clr & ~r & at_end;
   assign bus.q   = q_reg;
   assign bus.ovf = ovf_reg;

   always_ff @(posedge clk or posedge r) begin
      if (r) begin
         q_reg   <= '0;
         ovf_reg <= 1'b0;
      end else if (bus.clr) begin
         q_reg   <= '0;
         ovf_reg <= 1'b0;
      end else if (bus.ld) begin
         q_reg <= ld_val;
      end else if (bus.en) begin
         if (at_end) begin
            ovf_reg <= 1'b1;
            if (SATURATE == 0)
               q_reg <= bus.up ? '0 : TOP;
         end else begin
            q_reg <= bus.up ? q_reg + WIDTH'(1) : q_reg - WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_counter_updn.sv
// Scoreboard bench for counter_updn: wrap, saturate, clamp, cascade and full-binary configurations.
module tb_counter_updn;

   logic clk = 1'b0;
   logic r;
   always #5 clk = ~clk;

   counter_updn_if #(.WIDTH(4)) bus_w ();
   counter_updn_if #(.WIDTH(4)) bus_s ();
   counter_updn_if #(.WIDTH(4)) bus_u ();
   counter_updn_if #(.WIDTH(4)) bus_t ();
   counter_updn_if #(.WIDTH(3)) bus_b ();

   counter_updn #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_w (.clk(clk), .r(r), .bus(bus_w));
   counter_updn #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut_s (.clk(clk), .r(r), .bus(bus_s));
   counter_updn #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_u (.clk(clk), .r(r), .bus(bus_u));
   counter_updn #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_t (.clk(clk), .r(r), .bus(bus_t));
   counter_updn #(.WIDTH(3), .MODULUS(8),  .SATURATE(0)) dut_b (.clk(clk), .r(r), .bus(bus_b));

   // Tens stage counts on the units stage's terminal count.
   assign bus_t.en = bus_u.tc;

   typedef struct {
      int idx;
      int q;
      bit ovf;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   // Reference state per instance: 0 wrap, 1 saturate, 2 units, 3 tens, 4 binary.
   int mq [5];
   bit mo [5];
   int modv [5] = '{10, 10, 10, 10, 8};
   bit satv [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   function automatic int obs_q(input int i);
      case (i)
         0: return int'(bus_w.q);
         1: return int'(bus_s.q);
         2: return int'(bus_u.q);
         3: return int'(bus_t.q);
         default: return int'(bus_b.q);
      endcase
   endfunction

   function automatic int obs_ovf(input int i);
      case (i)
         0: return int'(bus_w.ovf);
         1: return int'(bus_s.ovf);
         2: return int'(bus_u.ovf);
         3: return int'(bus_t.ovf);
         default: return int'(bus_b.ovf);
      endcase
   endfunction

   function automatic int obs_tc(input int i);
      case (i)
         0: return int'(bus_w.tc);
         1: return int'(bus_s.tc);
         2: return int'(bus_u.tc);
         3: return int'(bus_t.tc);
         default: return int'(bus_b.tc);
      endcase
   endfunction

   task automatic drive(input int i, input bit c, input bit l, input int dv, input bit e, input bit u);
      case (i)
         0: begin bus_w.clr = c; bus_w.ld = l; bus_w.d = 4'(dv); bus_w.en = e; bus_w.up = u; end
         1: begin bus_s.clr = c; bus_s.ld = l; bus_s.d = 4'(dv); bus_s.en = e; bus_s.up = u; end
         2: begin bus_u.clr = c; bus_u.ld = l; bus_u.d = 4'(dv); bus_u.en = e; bus_u.up = u; end
         3: begin bus_t.clr = c; bus_t.ld = l; bus_t.d = 4'(dv); bus_t.up = u; end
         default: begin bus_b.clr = c; bus_b.ld = l; bus_b.d = 3'(dv); bus_b.en = e; bus_b.up = u; end
      endcase
   endtask

   // Behavioural next-state of one counter, written from the operation rules; r is low here.
   task automatic mstep(input int i, input bit c, input bit l, input int dv, input bit e, input bit u,
                        output bit tcx);
      int top;
      top = modv[i] - 1;
      tcx = e && !l && !c && (u ? (mq[i] == top) : (mq[i] == 0));
      if (c) begin
         mq[i] = 0;
         mo[i] = 1'b0;
      end else if (l) begin
         mq[i] = (dv < modv[i]) ? dv : top;
      end else if (e) begin
         if (u ? (mq[i] == top) : (mq[i] == 0)) begin
            mo[i] = 1'b1;
            if (!satv[i]) mq[i] = u ? 0 : top;
         end else begin
            mq[i] = u ? mq[i] + 1 : mq[i] - 1;
         end
      end
   endtask

   task automatic drain();
      exp_t x;
      while (sb.size() > 0) begin
         x = sb.pop_front();
         check($sformatf("q%0d", x.idx), obs_q(x.idx), x.q);
         check($sformatf("ovf%0d", x.idx), obs_ovf(x.idx), int'(x.ovf));
      end
   endtask

   task automatic step(input int i, input bit c, input bit l, input int dv, input bit e, input bit u);
      bit tcx;
      @(negedge clk);
      drive(i, c, l, dv, e, u);
      #1;
      mstep(i, c, l, dv, e, u, tcx);
      check($sformatf("tc%0d", i), obs_tc(i), int'(tcx));
      sb.push_back('{i, mq[i], mo[i]});
      @(posedge clk);
      #1;
      drain();
   endtask

   task automatic cstep(input bit e);
      bit tcu, tct;
      @(negedge clk);
      drive(2, 1'b0, 1'b0, 0, e, 1'b1);
      drive(3, 1'b0, 1'b0, 0, 1'b0, 1'b1);
      #1;
      mstep(2, 1'b0, 1'b0, 0, e, 1'b1, tcu);
      mstep(3, 1'b0, 1'b0, 0, tcu, 1'b1, tct);
      check("tc_units", obs_tc(2), int'(tcu));
      check("tc_tens", obs_tc(3), int'(tct));
      sb.push_back('{2, mq[2], mo[2]});
      sb.push_back('{3, mq[3], mo[3]});
      @(posedge clk);
      #1;
      drain();
   endtask

   initial begin
      for (int i = 0; i < 5; i++) begin
         drive(i, 1'b0, 1'b0, 0, 1'b0, 1'b1);
         mq[i] = 0;
         mo[i] = 1'b0;
      end
      r = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("rst_q%0d", i), obs_q(i), 0);
         check($sformatf("rst_ovf%0d", i), obs_ovf(i), 0);
         check($sformatf("rst_tc%0d", i), obs_tc(i), 0);
      end
      @(negedge clk);
      r = 1'b0;

      // Asynchronous reset between edges at q=7, with down-count enabled so tc masking matters.
      repeat (7) step(0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
      @(negedge clk);
      bus_w.up = 1'b0;
      bus_w.en = 1'b1;
      #1;
      r = 1'b1;
      #1;
      check("async_q", obs_q(0), 0);
      check("async_ovf", obs_ovf(0), 0);
      check("async_tc", obs_tc(0), 0);
      mq[0] = 0;
      mo[0] = 1'b0;
      bus_w.en = 1'b0;
      @(negedge clk);
      r = 1'b0;
      repeat (5) step(0, 1'b0, 1'b0, 0, 1'b0, 1'b1);

      // Decade wrap up, then down wrap from 0.
      repeat (12) step(0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
      step(0, 1'b1, 1'b0, 0, 1'b0, 1'b1);
      step(0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
      repeat (2) step(0, 1'b0, 1'b0, 0, 1'b1, 1'b0);

      // Saturating stage at both ends.
      repeat (3) step(1, 1'b0, 1'b0, 0, 1'b1, 1'b0);
      step(1, 1'b0, 1'b1, 9, 1'b0, 1'b1);
      repeat (3) step(1, 1'b0, 1'b0, 0, 1'b1, 1'b1);

      // Load clamp and priority on the wrapping stage.
      step(0, 1'b0, 1'b1, 13, 1'b0, 1'b1);
      step(0, 1'b0, 1'b1, 4, 1'b1, 1'b1);
      step(0, 1'b0, 1'b1, 10, 1'b0, 1'b1);
      step(0, 1'b0, 1'b1, 9, 1'b1, 1'b1);
      step(0, 1'b1, 1'b1, 5, 1'b1, 1'b1);
      step(0, 1'b0, 1'b1, 15, 1'b1, 1'b0);
      step(0, 1'b0, 1'b0, 0, 1'b1, 1'b0);

      // Two-stage decade cascade through 99 -> 00, then hold.
      repeat (100) cstep(1'b1);
      repeat (2) cstep(1'b0);

      // Full binary range: natural rollover is the wrap.
      repeat (9) step(4, 1'b0, 1'b0, 0, 1'b1, 1'b1);
      step(4, 1'b0, 1'b1, 7, 1'b0, 1'b1);
      step(4, 1'b0, 1'b0, 0, 1'b1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
